// File: rtl/vga_pattern_gen.sv
// ---------------------------------------------------------------------------
// vga_pattern_gen
//
// VGA timing generator with four built-in test patterns. It keeps a
// horizontal/vertical beam counter pair and registers every output from the
// counter state present before the clock edge. All outputs therefore arrive
// one cycle after the counters and stay aligned with each other.
//
// Parameters
//   C_resolution_x / C_resolution_y   active pixels per line / lines per frame
//   C_hsync_* / C_vsync_*             porch and pulse lengths (pixels / lines)
//   C_hsync_polarity / C_vsync_polarity  0 = active-low, 1 = active-high
//   C_depth                           bits per colour channel (1..8)
//
// Ports
//   clk_pixel    in   pixel clock (the only clock)
//   reset_n      in   asynchronous active-low reset
//   mode         in   0 solid, 1 colour bars, 2 grid, 3 gradient
//   color        in   solid colour {R,G,B}, R in the MSBs
//   red_p/green_p/blue_p  out  pixel colour, forced to 0 while blanking
//   hsync/vsync  out  sync pulses at the configured polarity
//   blank        out  1 outside the active area
//   frame_start  out  1 on the output cycle carrying pixel (0,0)
//   beam_x/beam_y out coordinates of the pixel on the outputs
//
// mode and color are only sampled at the last counter position of a frame,
// so a pattern change never tears a frame.
// ---------------------------------------------------------------------------
module vga_pattern_gen #(
    parameter int C_resolution_x      = 640,
    parameter int C_hsync_front_porch = 16,
    parameter int C_hsync_pulse       = 96,
    parameter int C_hsync_back_porch  = 48,
    parameter int C_resolution_y      = 480,
    parameter int C_vsync_front_porch = 10,
    parameter int C_vsync_pulse       = 2,
    parameter int C_vsync_back_porch  = 33,
    parameter int C_hsync_polarity    = 0,
    parameter int C_vsync_polarity    = 0,
    parameter int C_depth             = 3
) (
    input  logic                   clk_pixel,
    input  logic                   reset_n,
    input  logic [1:0]             mode,
    input  logic [3*C_depth-1:0]   color,
    output logic [C_depth-1:0]     red_p,
    output logic [C_depth-1:0]     green_p,
    output logic [C_depth-1:0]     blue_p,
    output logic                   hsync,
    output logic                   vsync,
    output logic                   blank,
    output logic                   frame_start,
    output logic [11:0]            beam_x,
    output logic [11:0]            beam_y
);

    localparam int H_TOTAL = C_resolution_x + C_hsync_front_porch
                           + C_hsync_pulse + C_hsync_back_porch;
    localparam int V_TOTAL = C_resolution_y + C_vsync_front_porch
                           + C_vsync_pulse + C_vsync_back_porch;

    localparam logic [11:0] RES_X      = 12'(C_resolution_x);
    localparam logic [11:0] RES_Y      = 12'(C_resolution_y);
    localparam logic [11:0] RES_X_LAST = 12'(C_resolution_x - 1);
    localparam logic [11:0] RES_Y_LAST = 12'(C_resolution_y - 1);
    localparam logic [11:0] H_LAST     = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_LAST     = 12'(V_TOTAL - 1);
    localparam logic [11:0] HS_START   = 12'(C_resolution_x + C_hsync_front_porch);
    localparam logic [11:0] HS_END     = 12'(C_resolution_x + C_hsync_front_porch + C_hsync_pulse);
    localparam logic [11:0] VS_START   = 12'(C_resolution_y + C_vsync_front_porch);
    localparam logic [11:0] VS_END     = 12'(C_resolution_y + C_vsync_front_porch + C_vsync_pulse);
    // Guard against a zero divisor for very narrow test resolutions.
    localparam logic [11:0] BAR_W      = 12'((C_resolution_x >= 8) ? C_resolution_x / 8 : 1);

    localparam logic HS_ON = (C_hsync_polarity != 0);
    localparam logic VS_ON = (C_vsync_polarity != 0);
    localparam logic [C_depth-1:0] ONES = '1;

    typedef enum logic [1:0] {
        MODE_SOLID = 2'd0,
        MODE_BARS  = 2'd1,
        MODE_GRID  = 2'd2,
        MODE_GRAD  = 2'd3
    } mode_t;

    logic [11:0]          h_cnt;
    logic [11:0]          v_cnt;
    logic [7:0]           frame_count;
    mode_t                shadow_mode;
    logic [3*C_depth-1:0] shadow_color;

    logic                 active;
    logic                 hs_act;
    logic                 vs_act;
    logic                 frame_end;
    logic                 grid_on;
    logic [11:0]          bar_q;
    logic [2:0]           bar_idx;
    logic [C_depth-1:0]   pix_r;
    logic [C_depth-1:0]   pix_g;
    logic [C_depth-1:0]   pix_b;

    assign active    = (h_cnt < RES_X) && (v_cnt < RES_Y);
    assign hs_act    = (h_cnt >= HS_START) && (h_cnt < HS_END);
    assign vs_act    = (v_cnt >= VS_START) && (v_cnt < VS_END);
    assign frame_end = (h_cnt == H_LAST) && (v_cnt == V_LAST);

    // Bar index saturates at 7 so any remainder pixels join the last bar.
    assign bar_q   = h_cnt / BAR_W;
    assign bar_idx = (bar_q > 12'd7) ? 3'd7 : bar_q[2:0];

    assign grid_on = (h_cnt[4:0] == 5'd0) || (v_cnt[4:0] == 5'd0)
                  || (h_cnt == RES_X_LAST) || (v_cnt == RES_Y_LAST);

    // NOTE: every always_comb output gets a default first so that no path
    // leaves it unassigned and infers a latch.
    always_comb begin
        pix_r = '0;
        pix_g = '0;
        pix_b = '0;
        if (active) begin
            case (shadow_mode)
                MODE_SOLID: begin
                    pix_r = shadow_color[3*C_depth-1:2*C_depth];
                    pix_g = shadow_color[2*C_depth-1:C_depth];
                    pix_b = shadow_color[C_depth-1:0];
                end
                MODE_BARS: begin
                    pix_r = bar_idx[2] ? ONES : '0;
                    pix_g = bar_idx[1] ? ONES : '0;
                    pix_b = bar_idx[0] ? ONES : '0;
                end
                MODE_GRID: begin
                    pix_r = grid_on ? ONES : '0;
                    pix_g = grid_on ? ONES : '0;
                    pix_b = grid_on ? ONES : '0;
                end
                MODE_GRAD: begin
                    // 12-bit sum wraps modulo 4096 before the slice is taken.
                    pix_r = C_depth'((h_cnt + {4'd0, frame_count}) >> 4);
                    pix_g = C_depth'(v_cnt >> 4);
                    pix_b = C_depth'(frame_count >> (8 - C_depth));
                end
            endcase
        end
    end

    // Beam counters, frame counter and per-frame shadow of mode/color.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            h_cnt        <= '0;
            v_cnt        <= '0;
            frame_count  <= '0;
            shadow_mode  <= MODE_BARS;
            shadow_color <= '0;
        end else begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? 12'd0 : v_cnt + 12'd1;
            end else begin
                h_cnt <= h_cnt + 12'd1;
            end
            if (frame_end) begin
                shadow_mode  <= mode_t'(mode);
                shadow_color <= color;
                frame_count  <= frame_count + 8'd1;
            end
        end
    end

    // Output stage: one register per output, all fed from the same counter
    // state so they stay mutually aligned.
    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            red_p       <= '0;
            green_p     <= '0;
            blue_p      <= '0;
            hsync       <= ~HS_ON;
            vsync       <= ~VS_ON;
            blank       <= 1'b1;
            frame_start <= 1'b0;
            beam_x      <= '0;
            beam_y      <= '0;
        end else begin
            red_p       <= pix_r;
            green_p     <= pix_g;
            blue_p      <= pix_b;
            hsync       <= hs_act ? HS_ON : ~HS_ON;
            vsync       <= vs_act ? VS_ON : ~VS_ON;
            blank       <= ~active;
            frame_start <= (h_cnt == 12'd0) && (v_cnt == 12'd0);
            beam_x      <= h_cnt;
            beam_y      <= v_cnt;
        end
    end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_pattern_gen
//
// Three generator instances with small timings share one clock and reset:
//   dut 0 (a): 40x36, depth 3, active-low syncs  - bars, solid, grid, gradient
//   dut 1 (b): 8x2,   depth 3, active-high syncs - gradient across 256 frames
//   dut 2 (c): 16x4,  depth 1, active-high syncs - 1-bit bars and sync polarity
// A behavioural model per instance pushes the expected output for each edge
// into a queue; after the edge the entry is popped and compared with the DUT.
// Directed checks at chosen pixels run on top of the per-cycle comparison.
// ---------------------------------------------------------------------------
module tb_vga_pattern_gen;

    typedef struct packed {
        int rx, hfp, hp, hbp, ry, vfp, vp, vbp, d, hpol, vpol;
    } cfg_t;

    typedef struct packed {
        logic       blank, hs, vs, fs;
        logic [7:0] r, g, b;
        logic [11:0] bx, by;
    } px_t;

    logic clk_pixel = 1'b0;
    logic reset_n   = 1'b1;

    logic [1:0] mode_a, mode_b, mode_c;
    logic [8:0] color_a, color_b;
    logic [2:0] color_c;

    logic [2:0]  red_a, green_a, blue_a;
    logic [2:0]  red_b, green_b, blue_b;
    logic [0:0]  red_c, green_c, blue_c;
    logic        hsync_a, vsync_a, blank_a, fs_a;
    logic        hsync_b, vsync_b, blank_b, fs_b;
    logic        hsync_c, vsync_c, blank_c, fs_c;
    logic [11:0] bx_a, by_a, bx_b, by_b, bx_c, by_c;

    int n_checks = 0;
    int n_fail   = 0;

    px_t sb_q[$];

    int m_x[3], m_y[3], m_fc[3], m_md[3], m_col[3];

    always #5 clk_pixel = ~clk_pixel;

    vga_pattern_gen #(
        .C_resolution_x(40), .C_hsync_front_porch(2), .C_hsync_pulse(3), .C_hsync_back_porch(2),
        .C_resolution_y(36), .C_vsync_front_porch(1), .C_vsync_pulse(2), .C_vsync_back_porch(1),
        .C_hsync_polarity(0), .C_vsync_polarity(0), .C_depth(3)
    ) dut_a (
        .clk_pixel(clk_pixel), .reset_n(reset_n), .mode(mode_a), .color(color_a),
        .red_p(red_a), .green_p(green_a), .blue_p(blue_a),
        .hsync(hsync_a), .vsync(vsync_a), .blank(blank_a), .frame_start(fs_a),
        .beam_x(bx_a), .beam_y(by_a)
    );

    vga_pattern_gen #(
        .C_resolution_x(8), .C_hsync_front_porch(1), .C_hsync_pulse(1), .C_hsync_back_porch(1),
        .C_resolution_y(2), .C_vsync_front_porch(1), .C_vsync_pulse(1), .C_vsync_back_porch(1),
        .C_hsync_polarity(1), .C_vsync_polarity(1), .C_depth(3)
    ) dut_b (
        .clk_pixel(clk_pixel), .reset_n(reset_n), .mode(mode_b), .color(color_b),
        .red_p(red_b), .green_p(green_b), .blue_p(blue_b),
        .hsync(hsync_b), .vsync(vsync_b), .blank(blank_b), .frame_start(fs_b),
        .beam_x(bx_b), .beam_y(by_b)
    );

    vga_pattern_gen #(
        .C_resolution_x(16), .C_hsync_front_porch(1), .C_hsync_pulse(2), .C_hsync_back_porch(1),
        .C_resolution_y(4), .C_vsync_front_porch(1), .C_vsync_pulse(1), .C_vsync_back_porch(1),
        .C_hsync_polarity(1), .C_vsync_polarity(1), .C_depth(1)
    ) dut_c (
        .clk_pixel(clk_pixel), .reset_n(reset_n), .mode(mode_c), .color(color_c),
        .red_p(red_c), .green_p(green_c), .blue_p(blue_c),
        .hsync(hsync_c), .vsync(vsync_c), .blank(blank_c), .frame_start(fs_c),
        .beam_x(bx_c), .beam_y(by_c)
    );

    function automatic cfg_t cfg(input int k);
        cfg_t c;
        case (k)
            0:       c = '{40, 2, 3, 2, 36, 1, 2, 1, 3, 0, 0};
            1:       c = '{8, 1, 1, 1, 2, 1, 1, 1, 3, 1, 1};
            default: c = '{16, 1, 2, 1, 4, 1, 1, 1, 1, 1, 1};
        endcase
        return c;
    endfunction

    function automatic int in_mode(input int k);
        case (k)
            0:       return int'(mode_a);
            1:       return int'(mode_b);
            default: return int'(mode_c);
        endcase
    endfunction

    function automatic int in_col(input int k);
        case (k)
            0:       return int'(color_a);
            1:       return int'(color_b);
            default: return int'(color_c);
        endcase
    endfunction

    // Expected output for beam position (x,y) under the given frame state.
    function automatic px_t model_out(input int k, input int x, input int y,
                                      input int fc, input int md, input int col);
        cfg_t c;
        px_t  e;
        int   mask, r, g, b, i;
        logic hon, von, white;
        c    = cfg(k);
        mask = (1 << c.d) - 1;
        hon  = (c.hpol != 0);
        von  = (c.vpol != 0);
        r = 0; g = 0; b = 0;
        e = '0;
        e.bx    = 12'(x);
        e.by    = 12'(y);
        e.blank = !((x < c.rx) && (y < c.ry));
        e.hs    = ((x >= c.rx + c.hfp) && (x < c.rx + c.hfp + c.hp)) ? hon : !hon;
        e.vs    = ((y >= c.ry + c.vfp) && (y < c.ry + c.vfp + c.vp)) ? von : !von;
        e.fs    = (x == 0) && (y == 0);
        if (!e.blank) begin
            case (md)
                0: begin
                    r = (col >> (2 * c.d)) & mask;
                    g = (col >> c.d) & mask;
                    b = col & mask;
                end
                1: begin
                    i = x / (c.rx / 8);
                    if (i > 7) i = 7;
                    r = ((i & 4) != 0) ? mask : 0;
                    g = ((i & 2) != 0) ? mask : 0;
                    b = ((i & 1) != 0) ? mask : 0;
                end
                2: begin
                    white = (x % 32 == 0) || (y % 32 == 0) || (x == c.rx - 1) || (y == c.ry - 1);
                    r = white ? mask : 0;
                    g = r;
                    b = r;
                end
                default: begin
                    r = (((x + fc) % 4096) >> 4) & mask;
                    g = (y >> 4) & mask;
                    b = (fc >> (8 - c.d)) & mask;
                end
            endcase
        end
        e.r = 8'(r);
        e.g = 8'(g);
        e.b = 8'(b);
        return e;
    endfunction

    function automatic px_t reset_px(input int k);
        cfg_t c;
        px_t  e;
        c = cfg(k);
        e = '0;
        e.blank = 1'b1;
        e.hs    = !(c.hpol != 0);
        e.vs    = !(c.vpol != 0);
        return e;
    endfunction

    function automatic px_t obs(input int k);
        px_t o;
        o = '0;
        case (k)
            0: begin
                o.blank = blank_a; o.hs = hsync_a; o.vs = vsync_a; o.fs = fs_a;
                o.r = 8'(red_a); o.g = 8'(green_a); o.b = 8'(blue_a);
                o.bx = bx_a; o.by = by_a;
            end
            1: begin
                o.blank = blank_b; o.hs = hsync_b; o.vs = vsync_b; o.fs = fs_b;
                o.r = 8'(red_b); o.g = 8'(green_b); o.b = 8'(blue_b);
                o.bx = bx_b; o.by = by_b;
            end
            default: begin
                o.blank = blank_c; o.hs = hsync_c; o.vs = vsync_c; o.fs = fs_c;
                o.r = 8'(red_c); o.g = 8'(green_c); o.b = 8'(blue_c);
                o.bx = bx_c; o.by = by_c;
            end
        endcase
        return o;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_x[k] = 0; m_y[k] = 0; m_fc[k] = 0; m_md[k] = 1; m_col[k] = 0;
        end
    endtask

    task automatic model_adv(input int k);
        cfg_t c;
        int   ht, vt;
        c  = cfg(k);
        ht = c.rx + c.hfp + c.hp + c.hbp;
        vt = c.ry + c.vfp + c.vp + c.vbp;
        if (m_x[k] == ht - 1) begin
            m_x[k] = 0;
            if (m_y[k] == vt - 1) begin
                m_y[k]   = 0;
                m_md[k]  = in_mode(k);
                m_col[k] = in_col(k);
                m_fc[k]  = (m_fc[k] + 1) % 256;
            end else begin
                m_y[k] = m_y[k] + 1;
            end
        end else begin
            m_x[k] = m_x[k] + 1;
        end
    endtask

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // One clock: queue the expected outputs, advance the model, then compare.
    task automatic step();
        px_t e;
        for (int k = 0; k < 3; k++) begin
            sb_q.push_back(model_out(k, m_x[k], m_y[k], m_fc[k], m_md[k], m_col[k]));
            model_adv(k);
        end
        @(posedge clk_pixel);
        #1;
        for (int k = 0; k < 3; k++) begin
            e = sb_q.pop_front();
            check($sformatf("pixel dut%0d", k), 64'(obs(k)), 64'(e));
        end
    endtask

    task automatic run_to(input int k, input int x, input int y);
        int  n;
        px_t o;
        n = 0;
        o = obs(k);
        while (!((o.bx == 12'(x)) && (o.by == 12'(y))) && (n < 5000)) begin
            step();
            n++;
            o = obs(k);
        end
        check($sformatf("reach dut%0d (%0d,%0d)", k, x, y),
              64'((o.bx == 12'(x)) && (o.by == 12'(y))), 64'(1));
    endtask

    task automatic chk_rgb(input string tag, input int k, input int r, input int g, input int b);
        px_t o;
        o = obs(k);
        check(tag, 64'({o.r, o.g, o.b}), 64'({8'(r), 8'(g), 8'(b)}));
    endtask

    task automatic chk_bit(input string tag, input logic observed, input logic expected);
        check(tag, 64'(observed), 64'(expected));
    endtask

    task automatic chk_reset_all(input string tag);
        for (int k = 0; k < 3; k++)
            check($sformatf("%s dut%0d", tag, k), 64'(obs(k)), 64'(reset_px(k)));
    endtask

    initial begin
        mode_a  = 2'd1; color_a = 9'd0;
        mode_b  = 2'd3; color_b = 9'd0;
        mode_c  = 2'd1; color_c = 3'b101;
        model_reset();

        // Asynchronous reset before any clock edge.
        #1 reset_n = 1'b0;
        #1 chk_reset_all("reset async");
        @(posedge clk_pixel);
        #1 chk_reset_all("reset held");

        // Release: the first edge must carry pixel (0,0) with frame_start.
        reset_n = 1'b1;
        model_reset();
        step();
        chk_bit("first fs", fs_a, 1'b1);
        check("first beam", 64'({bx_a, by_a}), 64'(0));

        // 1-bit bars, active-high syncs.
        run_to(2, 1, 0);   chk_rgb("c bar x1", 2, 0, 0, 0);
        run_to(2, 2, 0);   chk_rgb("c bar x2", 2, 0, 0, 1);
        run_to(2, 15, 0);  chk_rgb("c bar x15", 2, 1, 1, 1);
        run_to(2, 16, 0);  chk_bit("c blank x16", blank_c, 1'b1);
                           chk_rgb("c rgb x16", 2, 0, 0, 0);
                           chk_bit("c hs x16", hsync_c, 1'b0);
        run_to(2, 17, 0);  chk_bit("c hs x17", hsync_c, 1'b1);
        run_to(2, 19, 0);  chk_bit("c hs x19", hsync_c, 1'b0);
        run_to(2, 0, 4);   chk_bit("c vs y4", vsync_c, 1'b0);
        run_to(2, 0, 5);   chk_bit("c vs y5", vsync_c, 1'b1);
        run_to(1, 9, 0);   chk_bit("b hs x9", hsync_b, 1'b1);

        // Bars and sync edges on the depth-3 active-low instance.
        run_to(0, 4, 0);   chk_rgb("a bar x4", 0, 0, 0, 0);
        run_to(0, 5, 0);   chk_rgb("a bar x5", 0, 0, 0, 7);
        run_to(0, 39, 0);  chk_rgb("a bar x39", 0, 7, 7, 7);
        run_to(0, 40, 0);  chk_bit("a blank x40", blank_a, 1'b1);
                           chk_rgb("a rgb x40", 0, 0, 0, 0);
        run_to(0, 41, 0);  chk_bit("a hs x41", hsync_a, 1'b1);
        run_to(0, 42, 0);  chk_bit("a hs x42", hsync_a, 1'b0);
        run_to(0, 44, 0);  chk_bit("a hs x44", hsync_a, 1'b0);
        run_to(0, 45, 0);  chk_bit("a hs x45", hsync_a, 1'b1);
        run_to(0, 0, 36);  chk_bit("a vs y36", vsync_a, 1'b1);
        run_to(0, 0, 37);  chk_bit("a vs y37", vsync_a, 1'b0);
        run_to(0, 0, 38);  chk_bit("a vs y38", vsync_a, 1'b0);
        run_to(0, 0, 39);  chk_bit("a vs y39", vsync_a, 1'b1);

        // Solid colour takes effect at the next frame.
        mode_a  = 2'd0;
        color_a = 9'o527;
        run_to(0, 0, 0);   chk_bit("a fs solid", fs_a, 1'b1);
                           chk_rgb("a solid 0,0", 0, 5, 2, 7);

        // Mid-frame switch to grid must not show until the next frame.
        run_to(0, 0, 20);
        mode_a = 2'd2;
        run_to(0, 10, 21); chk_rgb("a still solid", 0, 5, 2, 7);
        run_to(0, 0, 0);   chk_rgb("a grid 0,0", 0, 7, 7, 7);
        run_to(0, 32, 5);  chk_rgb("a grid 32,5", 0, 7, 7, 7);
        run_to(0, 5, 5);   chk_rgb("a grid 5,5", 0, 0, 0, 0);
        run_to(0, 5, 32);  chk_rgb("a grid 5,32", 0, 7, 7, 7);
        run_to(0, 38, 34); chk_rgb("a grid 38,34", 0, 0, 0, 0);
        run_to(0, 39, 35); chk_rgb("a grid 39,35", 0, 7, 7, 7);

        // Gradient.
        mode_a = 2'd3;
        run_to(0, 0, 0);   chk_rgb("a grad 0,0", 0, (m_fc[0] >> 4) & 7, 0, m_fc[0] >> 5);
        run_to(0, 12, 0);  chk_rgb("a grad 12,0", 0, ((12 + m_fc[0]) >> 4) & 7, 0, m_fc[0] >> 5);
        run_to(0, 0, 20);  chk_rgb("a grad 0,20", 0, (m_fc[0] >> 4) & 7, 1, m_fc[0] >> 5);

        // Reset mid-frame: immediate, then clean restart.
        mode_a = 2'd1;
        run_to(0, 30, 20);
        reset_n = 1'b0;
        #1 chk_reset_all("reset midframe");
        @(posedge clk_pixel);
        #1 chk_reset_all("reset midframe held");
        reset_n = 1'b1;
        model_reset();
        step();
        chk_bit("restart fs a", fs_a, 1'b1);
        check("restart beam a", 64'({bx_a, by_a}), 64'(0));
        chk_bit("restart fs c", fs_c, 1'b1);

        // Gradient over 256 frames: blue follows frame_count[7:5],
        // red at (0,0) follows frame_count[6:4].
        for (int f = 1; f <= 256; f++) begin
            step();
            run_to(1, 0, 0);
            chk_rgb($sformatf("b grad frame %0d", f), 1, ((f % 256) >> 4) & 7, 0, (f % 256) >> 5);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
